// File: rtl/req_arbiter7.sv
// Seven-way request arbiter with sequenced grant/release, bounded hold time and a recovery cycle.
// Define ARB_ROUND_ROBIN_EN for rotating priority; the default build uses fixed highest-index priority.
module req_arbiter7 #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [6:0] req,
    output logic [6:0] gnt,
    output logic [2:0] gnt_id,
    output logic       busy,
    output logic       timeout
);

    localparam int CNT_W = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RECOVER
    } state_t;

    state_t           state_q, state_d;
    logic [6:0]       gnt_q, gnt_d;
    logic [2:0]       gnt_id_q, gnt_id_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [2:0]       pick_idx;
    logic             pick_vld;

`ifdef ARB_ROUND_ROBIN_EN
    logic [2:0] ptr_q, ptr_d;

    // Search ptr-1 downward with wrap; iterating k from 7 to 1 lets the nearest candidate win last.
    always_comb begin
        logic [2:0] cand;
        pick_idx = '0;
        pick_vld = 1'b0;
        for (int k = 7; k >= 1; k--) begin
            cand = 3'((int'(ptr_q) + 7 - k) % 7);
            if (req[cand]) begin
                pick_idx = cand;
                pick_vld = 1'b1;
            end
        end
    end
`else
    always_comb begin
        pick_idx = '0;
        pick_vld = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (req[i]) begin
                pick_idx = 3'(i);
                pick_vld = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_d     = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                gnt_d    = '0;
                gnt_id_d = '0;
                busy_d   = 1'b0;
                if (en && pick_vld) begin
                    gnt_d    = 7'(1) << pick_idx;
                    gnt_id_d = pick_idx + 3'd1;
                    busy_d   = 1'b1;
                    cnt_d    = (HOLD_MAX != 0) ? CNT_W'(1) : cnt_q;
                    state_d  = GRANT;
`ifdef ARB_ROUND_ROBIN_EN
                    ptr_d    = pick_idx;
`endif
                end
            end
            GRANT: begin
                if (!en || (req & gnt_q) == '0 ||
                    (HOLD_MAX != 0 && cnt_q == CNT_W'(HOLD_MAX))) begin
                    gnt_d    = '0;
                    gnt_id_d = '0;
                    busy_d   = 1'b0;
                    cnt_d    = '0;
                    state_d  = en ? RECOVER : IDLE;
                    // Only a hold-time revocation pulses timeout; abort and release stay quiet.
                    timeout_d = en && (req & gnt_q) != '0;
                end else if (HOLD_MAX != 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RECOVER: begin
                gnt_d    = '0;
                gnt_id_d = '0;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                gnt_d    = '0;
                gnt_id_d = '0;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: doc/req_arbiter7.md
Name: req_arbiter7

Overview:
- Arbitrates a single shared resource among 7 requesters, req[6:0].
- Uses the same priority-encoding convention as the team's 8-to-3 encoder: gnt_id = winning index + 1, and 0 means no grant.
- Adds state around the encoder: sequenced grant/release, a bounded hold time, and a dead cycle between owners.
- Sits in front of any shared datapath resource (bus, RAM port) that more than one client drives.

Parameters:
- HOLD_MAX, 16: maximum cycles a grant may stay asserted. 0 disables the timeout.
- CNT_W, $clog2(HOLD_MAX+1) (minimum 1): hold-counter width. Derived; do not override.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  arbitration enable; gates new grants and aborts a live grant.
- req  input  7  request vector; req[i] is held high by requester i until it is done.
- gnt  output  7  one-hot grant; registered.
- gnt_id  output  3  encoded grant (index+1), 0 when idle; registered; always consistent with gnt.
- busy  output  1  high while in GRANT.
- timeout  output  1  one-cycle pulse when a grant is revoked by HOLD_MAX.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, gnt=0, gnt_id=0, busy=0, timeout=0, hold counter=0, RR pointer=0.
  - Takes priority over everything, including mid-grant; outputs read 0 after that edge.
- States: IDLE, GRANT, RECOVER.
- IDLE:
  - If en=1 and req!=0 at edge N: latch the winner. After edge N, gnt/gnt_id/busy show the winner; state=GRANT; counter=1.
  - Latency from request to grant is 1 cycle.
  - Otherwise stay in IDLE with outputs 0.
- Winner selection (default, fixed priority): the highest set index wins. Examples: req=0000111 gives id 3; 0011000 gives id 5; 1111111 gives id 7.
- GRANT, evaluated each edge in this priority order:
  - (a) en=0: gnt, gnt_id and busy go to 0 at that edge; next state IDLE; no timeout pulse.
  - (b) req[winner]=0: release. Outputs go to 0; next state RECOVER.
  - (c) HOLD_MAX!=0 and counter==HOLD_MAX: revoke. Outputs go to 0; timeout=1 for exactly that cycle; next state RECOVER.
  - (d) Otherwise: hold the grant and increment the counter.
  - Consequence: a grant is visible for at most HOLD_MAX consecutive cycles.
- Other requesters' bits changing during GRANT are ignored; there is no preemption.
- RECOVER: one cycle with all outputs 0 (timeout may be high in this cycle per GRANT (c)); then IDLE unconditionally.
- Minimum gap between consecutive grants: 2 cycles with gnt=0 (RECOVER, then IDLE arbitration).
- Counter saturates at HOLD_MAX; it never wraps. With HOLD_MAX=0 the counter is frozen and (c) never fires.
- gnt is always zero-hot or one-hot, never multi-hot.
- req bits are assumed synchronous to clk; no synchronizers inside.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: rotating priority.
  - A 3-bit pointer holds the last granted index and updates when a grant is issued.
  - Search order is pointer-1 descending, wrapping 0 to 6, ending at the pointer itself. The last owner therefore gets lowest priority.
  - Reset pointer=0, so the first search order is 6..0, identical to fixed priority.
- Undefined: fixed highest-index priority; the pointer logic is absent.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, en=1, req=0000111 at edge N: after N+1, gnt=0000100, gnt_id=3, busy=1.
- req=1111111 then drop req[6] while granted: gnt_id goes 7 → 0 (RECOVER) → 0 (IDLE) → 6 (fixed build). In the RR build the sequence is 7 → 6 → 5 → … on successive releases.
- en=0 with req=1111111 for 10 cycles: gnt=0, gnt_id=0, busy=0 throughout. Then, with a grant active, drop en: grant clears at the next edge and timeout stays 0.
- HOLD_MAX=4, req=0011000 held continuously:
  - gnt_id=5 for exactly 4 cycles.
  - timeout pulses once, coincident with the first gnt=0 cycle.
  - After a 2-cycle gap, gnt_id=5 again (fixed build). The RR build grants gnt_id=4 instead.
- Assert rst mid-GRANT with req=0010110 held: all outputs 0 at the next edge. After rst deasserts, the re-grant shows gnt_id=5 one cycle later.
- Check every cycle of every test: gnt is one-hot or zero, gnt_id equals the encoding of gnt, and busy equals (gnt!=0).
